// File: rtl/echo_sample_buffer.sv
// rtl/echo_sample_buffer.sv - dual-memory triggered capture of S/X sample windows
// Optional macro ECHO_PEAK_EN adds rx_peak/rx_peak_idx outputs.
module echo_sample_buffer #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 6,
    parameter logic [DATA_W-1:0] TRIG_LVL = 16'd2000,
    parameter logic [15:0]     TIMEOUT  = 16'd5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [ADDR_W-1:0] rd_addr_s,
    input  logic [ADDR_W-1:0] rd_addr_x,
    output logic [DATA_W-1:0] rd_data_s,
    output logic [DATA_W-1:0] rd_data_x,
    output logic              busy,
    output logic              rdy,
`ifdef ECHO_PEAK_EN
    output logic [DATA_W-1:0] rx_peak,
    output logic [ADDR_W-1:0] rx_peak_idx,
`endif
    output logic              timeout
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [15:0]         tmo_cnt_q, tmo_cnt_d;
    logic                rdy_q, rdy_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rd_data_s_q, rd_data_s_d;
    logic [DATA_W-1:0]   rd_data_x_q, rd_data_x_d;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   tx_mag;
    logic [DATA_W-1:0]   mem_s [DEPTH];
    logic [DATA_W-1:0]   mem_x [DEPTH];

    // The most negative value has no positive twin, so it clamps to max.
    function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] v);
        if (!v[DATA_W-1])
            return v;
        else if (v == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else
            return (~v) + 1'b1;
    endfunction

    assign tx_mag = sat_abs(tx_data);

`ifdef ECHO_PEAK_EN
    logic [DATA_W-1:0] rx_mag;
    logic [DATA_W-1:0] rx_peak_q, rx_peak_d;
    logic [ADDR_W-1:0] rx_peak_idx_q, rx_peak_idx_d;
    assign rx_mag = sat_abs(rx_data);
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        tmo_cnt_d   = tmo_cnt_q;
        rdy_d       = rdy_q;
        timeout_d   = timeout_q;
        mem_we      = 1'b0;
        mem_addr    = wr_ptr_q;
        rd_data_s_d = mem_s[rd_addr_s];
        rd_data_x_d = mem_x[rd_addr_x];
`ifdef ECHO_PEAK_EN
        rx_peak_d     = rx_peak_q;
        rx_peak_idx_d = rx_peak_idx_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_ARM;
                    rdy_d     = 1'b0;
                    timeout_d = 1'b0;
                    wr_ptr_d  = '0;
                    tmo_cnt_d = '0;
`ifdef ECHO_PEAK_EN
                    rx_peak_d     = '0;
                    rx_peak_idx_d = '0;
`endif
                end
            end
            S_ARM: begin
                if (in_valid) begin
                    if (tx_mag >= TRIG_LVL) begin
                        mem_we   = 1'b1;
                        mem_addr = '0;
                        wr_ptr_d = ADDR_W'(1);
                        state_d  = S_CAPTURE;
                    end else if (tmo_cnt_q == TIMEOUT - 16'd1) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        rdy_d     = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    // Last slot: stop without wrapping onto sample 0.
                    if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef ECHO_PEAK_EN
        // Strict compare keeps the earliest index on ties.
        if (mem_we && (rx_mag > rx_peak_q)) begin
            rx_peak_d     = rx_mag;
            rx_peak_idx_d = mem_addr;
        end
`endif
        busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            tmo_cnt_q   <= '0;
            rdy_q       <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_data_s_q <= '0;
            rd_data_x_q <= '0;
`ifdef ECHO_PEAK_EN
            rx_peak_q     <= '0;
            rx_peak_idx_q <= '0;
`endif
        end else if (ena) begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rdy_q       <= rdy_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            rd_data_s_q <= rd_data_s_d;
            rd_data_x_q <= rd_data_x_d;
`ifdef ECHO_PEAK_EN
            rx_peak_q     <= rx_peak_d;
            rx_peak_idx_q <= rx_peak_idx_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ena && mem_we) begin
            mem_s[mem_addr] <= tx_data;
            mem_x[mem_addr] <= rx_data;
        end
    end

    assign rd_data_s = rd_data_s_q;
    assign rd_data_x = rd_data_x_q;
    assign busy      = busy_q;
    assign rdy       = rdy_q;
    assign timeout   = timeout_q;
`ifdef ECHO_PEAK_EN
    assign rx_peak     = rx_peak_q;
    assign rx_peak_idx = rx_peak_idx_q;
`endif

endmodule

// File: tb/tb_echo_sample_buffer.sv
// tb/tb_echo_sample_buffer.sv - directed self-checking bench for echo_sample_buffer
// Build with ECHO_PEAK_EN defined to also check the peak outputs.
module tb_echo_sample_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        start;
    logic        in_valid;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic [5:0]  rd_addr_s;
    logic [5:0]  rd_addr_x;
    logic [15:0] rd_data_s;
    logic [15:0] rd_data_x;
    logic        busy;
    logic        rdy;
    logic        timeout;
`ifdef ECHO_PEAK_EN
    logic [15:0] rx_peak;
    logic [5:0]  rx_peak_idx;
`endif

    int n_vec = 0;
    int n_err = 0;

    echo_sample_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .in_valid  (in_valid),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rd_addr_s (rd_addr_s),
        .rd_addr_x (rd_addr_x),
        .rd_data_s (rd_data_s),
        .rd_data_x (rd_data_x),
        .busy      (busy),
        .rdy       (rdy),
`ifdef ECHO_PEAK_EN
        .rx_peak     (rx_peak),
        .rx_peak_idx (rx_peak_idx),
`endif
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic rd(input logic [5:0] as, input logic [5:0] ax);
        rd_addr_s = as; rd_addr_x = ax;
        tick();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; in_valid = 1'b0;
        tx_data = '0; rx_data = '0; rd_addr_s = '0; rd_addr_x = '0;
        #2;
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        chk("reset_rd_s", 32'(rd_data_s), 32'd0);
        chk("reset_rd_x", 32'(rd_data_x), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Ramp capture: trigger on the 5th ramp value (2000).
        pulse_start();
        chk("t1_busy_arm", 32'(busy), 32'd1);
        for (int k = 0; k < 68; k++) begin
            in_valid = 1'b1;
            tx_data = 16'(500 * k);
            rx_data = 16'(500 * k - 1);
            tick();
            if (k == 66) chk("t1_rdy_before_last", 32'(rdy), 32'd0);
            if (k == 67) chk("t1_rdy_after_last", 32'(rdy), 32'd1);
        end
        in_valid = 1'b0;
        chk("t1_timeout", 32'(timeout), 32'd0);
        chk("t1_busy_done", 32'(busy), 32'd0);
        rd(6'd0, 6'd0);
        chk("t1_s0", 32'(rd_data_s), 32'h07D0);
        chk("t1_x0", 32'(rd_data_x), 32'h07CF);
        rd(6'd63, 6'd63);
        chk("t1_s63", 32'(rd_data_s), 32'h82DC);
        chk("t1_x63", 32'(rd_data_x), 32'h82DB);

        // Timeout: never reaches the trigger level.
        pulse_start();
        chk("t2_rdy_cleared", 32'(rdy), 32'd0);
        tx_data = 16'd100; rx_data = 16'd7; in_valid = 1'b1;
        for (int i = 1; i <= 5000; i++) begin
            tick();
            if (i == 4999) begin
                chk("t2_rdy_4999", 32'(rdy), 32'd0);
                chk("t2_busy_4999", 32'(busy), 32'd1);
            end
            if (i == 5000) begin
                chk("t2_rdy", 32'(rdy), 32'd1);
                chk("t2_timeout", 32'(timeout), 32'd1);
                chk("t2_busy", 32'(busy), 32'd0);
            end
        end
        in_valid = 1'b0;
        rd(6'd0, 6'd63);
        chk("t2_s0_unchanged", 32'(rd_data_s), 32'h07D0);
        chk("t2_x63_unchanged", 32'(rd_data_x), 32'h82DB);

        // Gapped capture, -32768 trigger, ignored start, ena freeze.
        pulse_start();
        chk("t3_timeout_cleared", 32'(timeout), 32'd0);
        rd_addr_s = 6'd0; rd_addr_x = 6'd0;
        in_valid = 1'b1; tx_data = 16'h8000; rx_data = 16'h2000;
        tick();
        chk("t3_busy_capture", 32'(busy), 32'd1);
        for (int idx = 1; idx < 64; idx++) begin
            if (idx == 30) begin
                chk("t3_rd_s_before_freeze", 32'(rd_data_s), 32'h8000);
                ena = 1'b0; in_valid = 1'b1; tx_data = 16'hBEEF; rd_addr_s = 6'd5;
                for (int f = 0; f < 10; f++) tick();
                chk("t3_freeze_rd_s", 32'(rd_data_s), 32'h8000);
                chk("t3_freeze_busy", 32'(busy), 32'd1);
                chk("t3_freeze_rdy", 32'(rdy), 32'd0);
                ena = 1'b1; rd_addr_s = 6'd0;
            end
            in_valid = 1'b0; tx_data = 16'hDEAD; rx_data = 16'hDEAD;
            tick();
            in_valid = 1'b1;
            tx_data = 16'h1000 + 16'(idx);
            rx_data = 16'h2000 + 16'(idx);
            start = (idx == 10);
            tick();
            start = 1'b0;
            if (idx == 10) chk("t3_start_ignored", 32'(busy), 32'd1);
            if (idx == 62) chk("t3_rdy_before_last", 32'(rdy), 32'd0);
            if (idx == 63) chk("t3_rdy_after_last", 32'(rdy), 32'd1);
        end
        in_valid = 1'b0;
        chk("t3_timeout", 32'(timeout), 32'd0);
        rd(6'd0, 6'd0);
        chk("t3_s0", 32'(rd_data_s), 32'h8000);
        chk("t3_x0", 32'(rd_data_x), 32'h2000);
        rd(6'd29, 6'd30);
        chk("t3_s29", 32'(rd_data_s), 32'h101D);
        chk("t3_x30", 32'(rd_data_x), 32'h201E);
        rd(6'd63, 6'd63);
        chk("t3_s63", 32'(rd_data_s), 32'h103F);
        chk("t3_x63", 32'(rd_data_x), 32'h203F);

        // Async reset in the middle of a capture, then a clean re-arm.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; tx_data = 16'h4000 + 16'(i); rx_data = 16'(i);
            tick();
        end
        chk("t4_busy_pre_rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_rdy", 32'(rdy), 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            tx_data = 16'h5000 + 16'(i);
            rx_data = (i == 10) ? 16'hF448 : (i == 20) ? 16'h0BB8 : 16'(i);
            tick();
            if (i == 62) chk("t4_rdy_before_last", 32'(rdy), 32'd0);
        end
        in_valid = 1'b0;
        chk("t4_rdy", 32'(rdy), 32'd1);
        chk("t4_timeout", 32'(timeout), 32'd0);
`ifdef ECHO_PEAK_EN
        chk("t4_rx_peak", 32'(rx_peak), 32'd3000);
        chk("t4_rx_peak_idx", 32'(rx_peak_idx), 32'd10);
`endif
        rd(6'd2, 6'd10);
        chk("t4_s2", 32'(rd_data_s), 32'h5002);
        chk("t4_x10", 32'(rd_data_x), 32'hF448);
        rd(6'd63, 6'd20);
        chk("t4_s63", 32'(rd_data_s), 32'h503F);
        chk("t4_x20", 32'(rd_data_x), 32'h0BB8);

        #3 rst = 1'b1;
        #1;
        chk("t5_rst_rdy", 32'(rdy), 32'd0);
        chk("t5_rst_rd_s", 32'(rd_data_s), 32'd0);
`ifdef ECHO_PEAK_EN
        chk("t5_rst_peak", 32'(rx_peak), 32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
